// File: rtl/pwm_fc_mod.sv
// Phase-shifted PWM modulator for an N-cell flying-capacitor leg.
// A master up-counter drives one triangular carrier per cell, each offset by
// 2*PERIOD/N_CELLS. A duty request is compared against each carrier. Each cell
// has a dead-time stage that keeps both of its switches off after every change
// and on every restart. A latched fault forces all gates off.
module pwm_fc_mod #(
  parameter int unsigned N_CELLS   = 4,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned PERIOD    = 1250,
  parameter int unsigned DEAD_TIME = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [CNT_W-1:0]     duty_i,
  input  logic                 duty_valid_i,
  output logic                 duty_ready_o,
  input  logic                 fault_i,
  input  logic                 fault_clr_i,
  output logic                 fault_o,
  output logic                 sync_o,
  output logic [2*N_CELLS-1:0] pwm_o
);

  localparam int unsigned Cw1 = CNT_W + 1;
  localparam int unsigned Cw2 = CNT_W + 2;
  localparam int unsigned P2  = 2 * PERIOD;
  localparam int unsigned DtW = (DEAD_TIME < 2) ? 1 : $clog2(DEAD_TIME + 1);

  localparam logic [Cw1-1:0] CntMax = Cw1'(P2 - 1);
  localparam logic [Cw1-1:0] PerW   = Cw1'(PERIOD);
  localparam logic [Cw2-1:0] P2W    = Cw2'(P2);
  localparam logic [Cw2-1:0] PerW2  = Cw2'(PERIOD);
  localparam logic [DtW-1:0] DtLoad = DtW'(DEAD_TIME);

  logic                 running;
  logic [Cw1-1:0]       cnt_q, cnt_d;
  logic [Cw1-1:0]       duty_q, duty_d;
  logic [Cw1-1:0]       pval_q, pval_d;
  logic [Cw1-1:0]       duty_cl;
  logic                 pend_q, pend_d;
  logic                 hs;
  logic [N_CELLS-1:0]   raw_q, raw_d;
  logic [N_CELLS-1:0]   chg;
  logic                 run_q;
  logic [DtW-1:0]       dt_q [N_CELLS];
  logic [DtW-1:0]       dt_d [N_CELLS];
  logic [Cw2-1:0]       ps   [N_CELLS];
  logic [Cw2-1:0]       ph   [N_CELLS];
  logic [Cw2-1:0]       car  [N_CELLS];
  logic [2*N_CELLS-1:0] out_q, out_d;
  logic                 sync_q, sync_d;
  logic                 fault_q, fault_d;

  // The counter only runs while enabled and free of faults.
  assign running      = en_i & ~fault_q;
  assign duty_ready_o = ~pend_q;
  assign fault_o      = fault_q;
  assign sync_o       = sync_q;
  // Gate the outputs as soon as the fault latches, before the stages clear.
  assign pwm_o        = fault_q ? '0 : out_q;

  // Master counter: wraps at 2*PERIOD-1 and is held at zero when stopped.
  always_comb begin
    cnt_d = '0;
    if (running) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + Cw1'(1);
    end
  end

  // Duty handshake into a one-deep pending slot, applied only at a period boundary.
  always_comb begin
    duty_cl = ({1'b0, duty_i} > PerW) ? PerW : {1'b0, duty_i};
    hs      = duty_valid_i & ~pend_q;
    pend_d  = pend_q;
    pval_d  = pval_q;
    duty_d  = duty_q;
    if (pend_q && (cnt_d == '0)) begin
      duty_d = pval_q;
      pend_d = 1'b0;
    end
    if (hs) begin
      pend_d = 1'b1;
      pval_d = duty_cl;
    end
  end

  // Per-cell carrier, compare and dead-time stage.
  always_comb begin
    out_d = '0;
    for (int unsigned k = 0; k < N_CELLS; k++) begin
      ps[k]  = {1'b0, cnt_q} + Cw2'(k * P2 / N_CELLS);
      ph[k]  = (ps[k] >= P2W) ? ps[k] - P2W : ps[k];
      car[k] = (ph[k] < PerW2) ? ph[k] : P2W - Cw2'(1) - ph[k];
      raw_d[k] = running & ({1'b0, duty_q} > car[k]);
      // The first running cycle after a stop counts as a change so that a
      // restart always sits through a full dead time.
      chg[k] = (raw_d[k] != raw_q[k]) | ~run_q;
      if (!running || chg[k]) begin
        dt_d[k] = DtLoad;
      end else if (dt_q[k] != '0) begin
        dt_d[k] = dt_q[k] - DtW'(1);
      end else begin
        dt_d[k] = '0;
      end
      if (running && (dt_q[k] == '0)) begin
        out_d[2*k]   = raw_q[k];
        out_d[2*k+1] = ~raw_q[k];
      end
    end
  end

  // Fault latch: set wins over clear.
  always_comb begin
    fault_d = fault_q;
    if (fault_i) begin
      fault_d = 1'b1;
    end else if (fault_clr_i) begin
      fault_d = 1'b0;
    end
    // Registered one cycle after the counter shows zero so every period,
    // including the first after a restart, gets exactly one pulse.
    sync_d = running & (cnt_q == '0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      duty_q  <= '0;
      pval_q  <= '0;
      pend_q  <= 1'b0;
      raw_q   <= '0;
      run_q   <= 1'b0;
      out_q   <= '0;
      sync_q  <= 1'b0;
      fault_q <= 1'b0;
      for (int unsigned k = 0; k < N_CELLS; k++) begin
        dt_q[k] <= DtLoad;
      end
    end else begin
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      raw_q   <= raw_d;
      run_q   <= running;
      out_q   <= out_d;
      sync_q  <= sync_d;
      fault_q <= fault_d;
      for (int unsigned k = 0; k < N_CELLS; k++) begin
        dt_q[k] <= dt_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pwm_fc_mod.sv
// Scoreboarded bench for pwm_fc_mod with a cycle-level behavioural model.
module tb_pwm_fc_mod;

  localparam int NC  = 2;
  localparam int CW  = 12;
  localparam int PER = 100;
  localparam int DT  = 5;

  logic            clk;
  logic            rst_i, en_i, duty_valid_i, fault_i, fault_clr_i;
  logic [CW-1:0]   duty_i;
  logic            duty_ready_o, fault_o, sync_o;
  logic [2*NC-1:0] pwm_o;

  pwm_fc_mod #(
    .N_CELLS  (NC),
    .CNT_W    (CW),
    .PERIOD   (PER),
    .DEAD_TIME(DT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .duty_i      (duty_i),
    .duty_valid_i(duty_valid_i),
    .duty_ready_o(duty_ready_o),
    .fault_i     (fault_i),
    .fault_clr_i (fault_clr_i),
    .fault_o     (fault_o),
    .sync_o      (sync_o),
    .pwm_o       (pwm_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2*NC-1:0] pwm;
    logic            ready;
    logic            sync;
    logic            fault;
  } exp_t;

  exp_t exp_q[$];
  int   errs = 0;
  int   chks = 0;
  int   cyc  = 0;

  // Model state: cnt as shown by the DUT during the current cycle.
  int   m_cnt, m_duty, m_pval;
  bit   m_pend, m_fault, m_acc;
  // Per-cell history of compare samples, newest first; -1 means stopped.
  int   hist[NC][DT+1];

  function automatic int carrier(int k, int c);
    int p;
    p = (c + k * 2 * PER / NC) % (2 * PER);
    return (p < PER) ? p : 2 * PER - 1 - p;
  endfunction

  task automatic check(input string name, input int got, input int want);
    chks++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: a gate is on once its compare result has held steady for
  // DT+1 consecutive running samples; any change or stop restarts the wait.
  always @(posedge clk) begin
    exp_t e;
    bit   run, ok;
    int   nxt;
    cyc++;
    m_acc = 1'b0;
    e.pwm = '0;
    if (rst_i) begin
      m_cnt = 0; m_duty = 0; m_pval = 0; m_pend = 0; m_fault = 0;
      for (int k = 0; k < NC; k++)
        for (int j = 0; j <= DT; j++) hist[k][j] = -1;
      e.ready = 1'b1;
      e.sync  = 1'b0;
      e.fault = 1'b0;
    end else begin
      run = en_i && !m_fault;
      for (int k = 0; k < NC; k++) begin
        ok = run;
        for (int j = 0; j <= DT; j++)
          if (hist[k][j] < 0 || hist[k][j] != hist[k][0]) ok = 1'b0;
        if (ok) begin
          e.pwm[2*k]   = (hist[k][0] == 1);
          e.pwm[2*k+1] = (hist[k][0] == 0);
        end
      end
      e.sync = run && (m_cnt == 0);
      for (int k = 0; k < NC; k++) begin
        for (int j = DT; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = run ? ((m_duty > carrier(k, m_cnt)) ? 1 : 0) : -1;
      end
      nxt = run ? (m_cnt + 1) % (2 * PER) : 0;
      if (duty_valid_i && !m_pend) begin
        m_acc = 1'b1;
      end
      if (m_pend && nxt == 0) begin
        m_duty = m_pval;
        m_pend = 1'b0;
      end
      if (m_acc) begin
        m_pend = 1'b1;
        m_pval = (int'(duty_i) > PER) ? PER : int'(duty_i);
      end
      m_cnt = nxt;
      if (fault_i) m_fault = 1'b1;
      else if (fault_clr_i) m_fault = 1'b0;
      if (m_fault) e.pwm = '0;
      e.ready = !m_pend;
      e.fault = m_fault;
    end
    exp_q.push_back(e);
  end

  // Monitor: compare every presented output bundle with the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chks++;
        if (pwm_o !== e.pwm || duty_ready_o !== e.ready || sync_o !== e.sync ||
            fault_o !== e.fault) begin
          errs++;
          if (errs <= 20)
            $display("FAIL scoreboard cycle %0d: got pwm=%b rdy=%b sync=%b flt=%b, expected pwm=%b rdy=%b sync=%b flt=%b",
                     cyc, pwm_o, duty_ready_o, sync_o, fault_o, e.pwm, e.ready, e.sync, e.fault);
        end
      end
    end
  end

  task automatic send(input int v);
    bit acc;
    acc = 1'b0;
    duty_i = CW'(v);
    duty_valid_i = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (m_acc) begin
        acc = 1'b1;
        break;
      end
    end
    duty_valid_i = 1'b0;
    check("send accepted", int'(acc), 1);
  endtask

  task automatic wait_cnt(input int v);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (m_cnt == v) begin
        hit = 1'b1;
        break;
      end
    end
    check("wait for counter", int'(hit), 1);
  endtask

  // Counts cycles over a window where pwm_o differs from a steady value.
  task automatic steady(input string name, input logic [2*NC-1:0] v);
    int bad;
    bad = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge clk);
      if (pwm_o !== v) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    int h0, h1, both, r0, r1, bad;
    logic [2*NC-1:0] prev;
    bit found;
    rst_i = 1'b1; en_i = 1'b0; duty_i = '0; duty_valid_i = 1'b0;
    fault_i = 1'b0; fault_clr_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset pwm", int'(pwm_o), 0);
    check("reset ready", int'(duty_ready_o), 1);
    check("reset fault/sync", int'({fault_o, sync_o}), 0);
    rst_i = 1'b0;
    en_i  = 1'b1;

    // Duty 50: on-time, phase shift and complementary pairs.
    send(50);
    repeat (600) @(negedge clk);
    h0 = 0; h1 = 0; both = 0; r0 = -1; r1 = -1;
    prev = pwm_o;
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge clk);
      h0 += int'(pwm_o[0]);
      h1 += int'(pwm_o[2]);
      if ((pwm_o[0] && pwm_o[1]) || (pwm_o[2] && pwm_o[3])) both++;
      if (pwm_o[0] && !prev[0] && r0 < 0) r0 = i;
      if (pwm_o[2] && !prev[2] && r1 < 0) r1 = i;
      prev = pwm_o;
    end
    check("cell0 high time", h0, PER - DT);
    check("cell1 high time", h1, PER - DT);
    check("pair overlap", both, 0);
    check("cell1 shift", (r0 >= 0 && r1 >= 0) ? (r1 - r0 + 2 * PER) % (2 * PER) : -1, PER);

    // Duty 0, then full duty, then clamped over-range duty.
    send(0);
    repeat (400) @(negedge clk);
    steady("duty 0 low sides", 4'b1010);
    send(PER);
    repeat (400) @(negedge clk);
    steady("duty full high sides", 4'b0101);
    send(0);
    repeat (400) @(negedge clk);
    send(4095);
    repeat (400) @(negedge clk);
    steady("duty clamped", 4'b0101);

    // Handshake mid-period: ready stays low until the wrap, second request waits.
    wait_cnt(30);
    duty_i = CW'(80);
    duty_valid_i = 1'b1;
    @(negedge clk);
    check("ready after handshake", int'(duty_ready_o), 0);
    duty_i = CW'(20);
    bad = 0;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_cnt == 0) begin
        found = 1'b1;
        break;
      end
      if (duty_ready_o) bad++;
    end
    check("ready held low until wrap", bad, 0);
    check("wrap reached", int'(found), 1);
    check("ready at wrap", int'(duty_ready_o), 1);
    @(negedge clk);
    check("held-off request accepted", int'(m_acc), 1);
    duty_valid_i = 1'b0;
    repeat (300) @(negedge clk);

    // Fault pulse mid-period, sticky clear, then proper clear.
    wait_cnt(60);
    fault_i = 1'b1;
    @(negedge clk);
    fault_i = 1'b0;
    check("fault latched", int'(fault_o), 1);
    check("fault pwm off", int'(pwm_o), 0);
    repeat (20) @(negedge clk);
    fault_i = 1'b1;
    fault_clr_i = 1'b1;
    @(negedge clk);
    check("fault kept", int'(fault_o), 1);
    fault_i = 1'b0;
    fault_clr_i = 1'b0;
    repeat (5) @(negedge clk);
    fault_clr_i = 1'b1;
    @(negedge clk);
    fault_clr_i = 1'b0;
    check("fault cleared", int'(fault_o), 0);
    bad = 0;
    for (int i = 0; i < DT + 1; i++) begin
      @(negedge clk);
      if (pwm_o != '0) bad++;
    end
    check("restart dead time", bad, 0);

    // Reset inside a dead time with duty 50 running.
    send(50);
    repeat (400) @(negedge clk);
    found = 1'b0;
    prev = pwm_o;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (prev[0] && !pwm_o[0]) begin
        found = 1'b1;
        break;
      end
      prev = pwm_o;
    end
    check("falling edge seen", int'(found), 1);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("mid dead-time reset pwm", int'(pwm_o), 0);
    check("mid dead-time reset ready", int'(duty_ready_o), 1);
    check("mid dead-time reset fault/sync", int'({fault_o, sync_o}), 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_acc) duty_valid_i = 1'b0;
      if (!duty_valid_i && $urandom_range(0, 5) == 0) begin
        duty_valid_i = 1'b1;
        case ($urandom_range(0, 3))
          0:       duty_i = '0;
          1:       duty_i = CW'(PER);
          2:       duty_i = CW'($urandom_range(101, 4095));
          default: duty_i = CW'($urandom_range(1, PER - 1));
        endcase
      end
      if ($urandom_range(0, 149) == 0) en_i = ~en_i;
      fault_i     = ($urandom_range(0, 299) == 0);
      fault_clr_i = ($urandom_range(0, 39) == 0);
      rst_i       = ($urandom_range(0, 699) == 0);
    end
    rst_i = 1'b0; fault_i = 1'b0; fault_clr_i = 1'b0; duty_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule

// File: doc/pwm_fc_mod.md
PWM_FC_MOD -- requirements
Module: pwm_fc_mod

Interface
REQ-001 Parameter N_CELLS, default 4: flying-capacitor cells (switch pairs); SHALL be ≥1 and divide 2*PERIOD.
REQ-002 Parameter CNT_W, default 12: counter and duty width.
REQ-003 Parameter PERIOD, default 1250: carrier half-period in clocks; SHALL be < 2^CNT_W.
REQ-004 Parameter DEAD_TIME, default 10: dead time in clocks; SHALL be ≥1 and < PERIOD/2.
REQ-005 clk_i  in  1  system clock; all logic on rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 en_i  in  1  modulator enable.
REQ-008 duty_i  in  CNT_W  requested duty, 0..PERIOD.
REQ-009 duty_valid_i  in  1  duty request valid.
REQ-010 duty_ready_o  out  1  block can accept a duty request.
REQ-011 fault_i  in  1  external fault, active-high.
REQ-012 fault_clr_i  in  1  fault latch clear request.
REQ-013 fault_o  out  1  latched fault status.
REQ-014 sync_o  out  1  one-cycle pulse at each carrier period start.
REQ-015 pwm_o  out  2*N_CELLS  gate drives; bit 2k = cell k high side, bit 2k+1 = cell k low side.

Function
REQ-016 Master counter cnt SHALL count 0..2*PERIOD-1, wrap to 0, and advance only while en_i=1 and fault_o=0; otherwise it SHALL be held at 0.
REQ-017 Cell k phase position SHALL be p_k = (cnt + k*2*PERIOD/N_CELLS) mod 2*PERIOD; carrier c_k = p_k if p_k<PERIOD, else 2*PERIOD-1-p_k.
REQ-018 Registered compare raw_k SHALL be 1 when active_duty > c_k, else 0; duty 0 gives raw always 0, duty PERIOD gives raw always 1.
REQ-019 A handshake SHALL occur when duty_valid_i and duty_ready_o are both 1; the value, clamped to PERIOD if larger, SHALL be stored in a pending register.
REQ-020 duty_ready_o SHALL be 0 from the cycle after a handshake until the pending value is applied, and 1 otherwise.
REQ-021 The pending value SHALL be copied to active_duty on the cycle cnt wraps to 0, or immediately if cnt is held at 0; active_duty SHALL never change mid-period.
REQ-022 sync_o SHALL pulse for one cycle when cnt=0 while the counter is running.
REQ-023 Per cell dead-time stage: on a change of raw_k, both outputs of cell k SHALL go 0 and a counter SHALL load DEAD_TIME; at expiry, bit 2k SHALL be set to raw_k and bit 2k+1 to ~raw_k.
REQ-024 A raw_k change during an active dead time SHALL reload the counter; both outputs of a pair SHALL never be 1 together.
REQ-025 Latency from a counter crossing to a pwm_o rising edge SHALL be DEAD_TIME+2 clocks; falling edges SHALL occur 2 clocks after the crossing.
REQ-026 fault_i=1 SHALL set fault_o on the next clock; while fault_o=1, pwm_o SHALL be all 0.
REQ-027 fault_o SHALL clear only when fault_clr_i=1 and fault_i=0 in the same cycle; if fault_i and fault_clr_i are both 1, the fault SHALL be kept.
REQ-028 On fault or en_i=0, all dead-time counters SHALL load DEAD_TIME and raw_k SHALL be forced to 0; a restart SHALL begin with a full dead time.

Reset
REQ-029 In the cycle after rst_i=1, the following SHALL hold: cnt=0, active_duty=0, pending empty, duty_ready_o=1, pwm_o=0, sync_o=0, fault_o=0, raw_k=0, dead-time counters=DEAD_TIME.
REQ-030 Reset SHALL take priority over all inputs, including mid-period and mid-dead-time.

Verification
REQ-031 Setup N_CELLS=2, PERIOD=100, DEAD_TIME=5, en_i=1, duty=50. Expected: each high side is on 95 of 200 clocks; cell 1 is shifted 100 clocks from cell 0; pairs are never both high.
REQ-032 Duty 0, then duty 100 (PERIOD). Expected: with duty 0, high sides are 0 and low sides are 1 after 5 clocks; with duty 100, the reverse, with no toggling.
REQ-033 Handshake of duty 80 at cnt=30. Expected: duty_ready_o=0 until the wrap; new duty takes effect at cnt=0; a second valid during that interval is held off.
REQ-034 Duty 4095. Expected: clamped to 100; behaves as duty 100.
REQ-035 fault_i pulse mid-period. Expected: pwm_o=0 and fault_o=1 on the next clock. Then fault_clr_i with fault_i=1. Expected: fault is kept. Then clear with fault_i=0. Expected: restart from cnt=0 with a full dead time.
REQ-036 rst_i asserted during a dead time with duty 50 running. Expected: all REQ-029 values on the next clock.
